// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the memory-port arbiter: FSM state encodings,
//   requester IDs and default bus widths.
package mem_arbiter_pkg;

   localparam int DEF_DATA_WIDTH      = 32;
   localparam int DEF_ADDR_WIDTH      = 32;
   localparam int DEF_BYTE_DATA_WIDTH = DEF_DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_DONE = 2'd2
   } arb_state_t;

   localparam logic REQ_FETCH = 1'b0;
   localparam logic REQ_LSU   = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the fetch requester, LSU requester and memory-side signals of the
//   arbiter. Modports:
//     slave  - the arbiter: receives requests, serves them through the memory
//              port and returns f_valid/l_valid/rdata plus grant/busy status.
//     master - the environment: drives requests and memory responses.
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
   parameter int BYTE_DATA_WIDTH = DEF_BYTE_DATA_WIDTH
);
   // fetch requester
   logic                       f_req;
   logic [ADDR_WIDTH-1:0]      f_addr;
   logic                       f_valid;
   // LSU requester
   logic                       l_req;
   logic [ADDR_WIDTH-1:0]      l_addr;
   logic                       l_we;
   logic [DATA_WIDTH-1:0]      l_wdata;
   logic [BYTE_DATA_WIDTH-1:0] l_byte_enable;
   logic                       l_valid;
   // shared response data and status
   logic [DATA_WIDTH-1:0]      rdata;
   logic                       grant;
   logic                       busy;
   // memory side
   logic                       mem_req;
   logic                       mem_we;
   logic [ADDR_WIDTH-1:0]      mem_addr;
   logic [DATA_WIDTH-1:0]      mem_wdata;
   logic [BYTE_DATA_WIDTH-1:0] mem_byte_enable;
   logic                       mem_valid;
   logic [DATA_WIDTH-1:0]      mem_rdata;

   modport slave (
      input  f_req, f_addr, l_req, l_addr, l_we, l_wdata, l_byte_enable,
      input  mem_valid, mem_rdata,
      output f_valid, l_valid, rdata, grant, busy,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_byte_enable
   );

   modport master (
      output f_req, f_addr, l_req, l_addr, l_we, l_wdata, l_byte_enable,
      output mem_valid, mem_rdata,
      input  f_valid, l_valid, rdata, grant, busy,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_byte_enable
   );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// arb_rr_pick
//   Combinational 2-way round-robin picker.
//   Ports:
//     req        in  {f_req, l_req}
//     last_grant in  requester served most recently (0 = fetch, 1 = LSU)
//     pick_valid out at least one request is pending
//     pick_id    out chosen requester (0 = fetch, 1 = LSU)
module arb_rr_pick
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       pick_valid,
   output logic       pick_id
);

   logic f_req;
   logic l_req;

   assign f_req = req[1];
   assign l_req = req[0];

   always_comb begin
      pick_valid = f_req | l_req;
      pick_id    = REQ_FETCH;
      if (f_req && l_req) begin
         // conflict: the requester not served last time wins
         pick_id = ~last_grant;
      end else if (l_req) begin
         pick_id = REQ_LSU;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between the fetch unit and the LSU using the
//   four-phase req/valid handshake on both sides, with round-robin priority
//   and a single outstanding transaction. Every output is a flop.
//   Ports:
//     clk  in  rising-edge clock
//     rst  in  asynchronous active-low reset
//     bus  mem_arbiter_if.slave: requester inputs, f_valid/l_valid/rdata,
//          memory request/response, grant and busy status
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
   parameter int BYTE_DATA_WIDTH = DEF_BYTE_DATA_WIDTH
)(
   input  logic             clk,
   input  logic             rst,
   mem_arbiter_if.slave     bus
);

   arb_state_t                 state_reg;
   logic                       last_grant_reg;
   logic                       grant_reg;
   logic                       aborted_reg;
   logic                       f_valid_reg;
   logic                       l_valid_reg;
   logic                       busy_reg;
   logic                       mem_req_reg;
   logic                       mem_we_reg;
   logic [ADDR_WIDTH-1:0]      mem_addr_reg;
   logic [DATA_WIDTH-1:0]      mem_wdata_reg;
   logic [BYTE_DATA_WIDTH-1:0] mem_byte_enable_reg;
   logic [DATA_WIDTH-1:0]      rdata_reg;

   logic pick_valid;
   logic pick_id;
   logic owner_req;

   arb_rr_pick u_pick (
      .req        ({bus.f_req, bus.l_req}),
      .last_grant (last_grant_reg),
      .pick_valid (pick_valid),
      .pick_id    (pick_id)
   );

   // request line of whoever owns the current transaction
   assign owner_req = (grant_reg == REQ_LSU) ? bus.l_req : bus.f_req;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg           <= ARB_IDLE;
         last_grant_reg      <= REQ_LSU;   // fetch wins the first conflict
         grant_reg           <= REQ_FETCH;
         aborted_reg         <= 1'b0;
         f_valid_reg         <= 1'b0;
         l_valid_reg         <= 1'b0;
         busy_reg            <= 1'b0;
         mem_req_reg         <= 1'b0;
         mem_we_reg          <= 1'b0;
         mem_addr_reg        <= '0;
         mem_wdata_reg       <= '0;
         mem_byte_enable_reg <= '0;
         rdata_reg           <= '0;
      end else begin
         case (state_reg)
            ARB_IDLE: begin
               if (pick_valid) begin
                  grant_reg   <= pick_id;
                  aborted_reg <= 1'b0;
                  mem_req_reg <= 1'b1;
                  busy_reg    <= 1'b1;
                  state_reg   <= ARB_BUSY;
                  if (pick_id == REQ_LSU) begin
                     mem_we_reg          <= bus.l_we;
                     mem_addr_reg        <= bus.l_addr;
                     mem_wdata_reg       <= bus.l_wdata;
                     mem_byte_enable_reg <= bus.l_byte_enable;
                  end else begin
                     mem_we_reg          <= 1'b0;
                     mem_addr_reg        <= bus.f_addr;
                     mem_wdata_reg       <= '0;
                     mem_byte_enable_reg <= '1;
                  end
               end
            end
            ARB_BUSY: begin
               // once the owner has let go of req, the response is never
               // delivered even if req comes back before memory answers
               if (!owner_req) begin
                  aborted_reg <= 1'b1;
               end
               if (bus.mem_valid) begin
                  rdata_reg      <= bus.mem_rdata;
                  mem_req_reg    <= 1'b0;
                  last_grant_reg <= grant_reg;
                  state_reg      <= ARB_DONE;
                  if (owner_req && !aborted_reg) begin
                     if (grant_reg == REQ_LSU) begin
                        l_valid_reg <= 1'b1;
                     end else begin
                        f_valid_reg <= 1'b1;
                     end
                  end
               end
            end
            ARB_DONE: begin
               if (!owner_req && !bus.mem_valid) begin
                  f_valid_reg <= 1'b0;
                  l_valid_reg <= 1'b0;
                  busy_reg    <= 1'b0;
                  state_reg   <= ARB_IDLE;
               end
            end
            default: begin
               state_reg   <= ARB_IDLE;
               f_valid_reg <= 1'b0;
               l_valid_reg <= 1'b0;
               busy_reg    <= 1'b0;
               mem_req_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.f_valid         = f_valid_reg;
   assign bus.l_valid         = l_valid_reg;
   assign bus.rdata           = rdata_reg;
   assign bus.grant           = grant_reg;
   assign bus.busy            = busy_reg;
   assign bus.mem_req         = mem_req_reg;
   assign bus.mem_we          = mem_we_reg;
   assign bus.mem_addr        = mem_addr_reg;
   assign bus.mem_wdata       = mem_wdata_reg;
   assign bus.mem_byte_enable = mem_byte_enable_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter: fetch read, LSU store, conflict ordering,
//   slow release, aborted request and asynchronous reset.
module tb_mem_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   mem_arbiter_if bus ();

   mem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // advance one rising edge; sample/drive 1 time unit after it
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      bus.f_req = 1'b0;         bus.f_addr = '0;
      bus.l_req = 1'b0;         bus.l_addr = '0;
      bus.l_we = 1'b0;          bus.l_wdata = '0;
      bus.l_byte_enable = '0;
      bus.mem_valid = 1'b0;     bus.mem_rdata = '0;

      // ---------------- reset values ----------------
      step(2);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_f_valid", bus.f_valid, 0);
      chk("rst_l_valid", bus.l_valid, 0);
      chk("rst_grant", bus.grant, 0);
      chk("rst_mem_be", bus.mem_byte_enable, 0);
      chk("rst_rdata", bus.rdata, 0);
      rst = 1'b1;
      step(1);

      // ---------------- fetch only ----------------
      bus.f_req = 1'b1; bus.f_addr = 32'h100;
      step(1);
      $display("txn fetch read addr=%h", bus.f_addr);
      chk("f_mem_req", bus.mem_req, 1);
      chk("f_mem_addr", bus.mem_addr, 32'h100);
      chk("f_mem_we", bus.mem_we, 0);
      chk("f_mem_be", bus.mem_byte_enable, 4'b1111);
      chk("f_grant", bus.grant, 0);
      chk("f_busy", bus.busy, 1);
      step(2);
      chk("f_wait_valid", bus.f_valid, 0);
      chk("f_wait_mem_req", bus.mem_req, 1);
      chk("f_wait_l_valid", bus.l_valid, 0);
      bus.mem_valid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
      step(1);
      chk("f_valid", bus.f_valid, 1);
      chk("f_rdata", bus.rdata, 32'hDEADBEEF);
      chk("f_mem_req_drop", bus.mem_req, 0);
      chk("f_l_valid", bus.l_valid, 0);
      bus.f_req = 1'b0; bus.mem_valid = 1'b0; bus.mem_rdata = '0;
      step(1);
      chk("f_rel_valid", bus.f_valid, 0);
      chk("f_rel_busy", bus.busy, 0);
      chk("f_rel_rdata_hold", bus.rdata, 32'hDEADBEEF);

      // ---------------- LSU store ----------------
      bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h2004;
      bus.l_wdata = 32'h12345678; bus.l_byte_enable = 4'b0011;
      step(1);
      $display("txn lsu store addr=%h data=%h be=%b", bus.l_addr, bus.l_wdata, bus.l_byte_enable);
      chk("s_mem_req", bus.mem_req, 1);
      chk("s_mem_we", bus.mem_we, 1);
      chk("s_mem_addr", bus.mem_addr, 32'h2004);
      chk("s_mem_wdata", bus.mem_wdata, 32'h12345678);
      chk("s_mem_be", bus.mem_byte_enable, 4'b0011);
      chk("s_grant", bus.grant, 1);
      bus.mem_valid = 1'b1;
      step(1);
      chk("s_l_valid", bus.l_valid, 1);
      chk("s_f_valid", bus.f_valid, 0);
      bus.l_req = 1'b0; bus.l_we = 1'b0; bus.mem_valid = 1'b0;
      step(1);
      chk("s_rel_valid", bus.l_valid, 0);
      chk("s_rel_busy", bus.busy, 0);

      // ---------------- conflict ----------------
      bus.f_req = 1'b1; bus.f_addr = 32'h200;
      bus.l_req = 1'b1; bus.l_addr = 32'h3000; bus.l_byte_enable = 4'b1111;
      step(1);
      $display("txn conflict pair 1 grant=%0d", bus.grant);
      chk("c1_grant", bus.grant, 0);
      chk("c1_mem_addr", bus.mem_addr, 32'h200);
      bus.mem_valid = 1'b1; bus.mem_rdata = 32'h11111111;
      step(1);
      chk("c1_f_valid", bus.f_valid, 1);
      chk("c1_l_valid", bus.l_valid, 0);
      bus.f_req = 1'b0; bus.mem_valid = 1'b0;
      step(1);
      chk("c1_idle_mem_req", bus.mem_req, 0);
      chk("c1_idle_busy", bus.busy, 0);
      step(1);
      $display("txn conflict lsu follow-up grant=%0d", bus.grant);
      chk("c2_grant", bus.grant, 1);
      chk("c2_mem_req", bus.mem_req, 1);
      chk("c2_mem_addr", bus.mem_addr, 32'h3000);
      bus.mem_valid = 1'b1; bus.mem_rdata = 32'h22222222;
      step(1);
      chk("c2_l_valid", bus.l_valid, 1);
      chk("c2_rdata", bus.rdata, 32'h22222222);
      bus.l_req = 1'b0; bus.mem_valid = 1'b0;
      step(1);
      chk("c2_rel_busy", bus.busy, 0);
      bus.f_req = 1'b1; bus.l_req = 1'b1;
      step(1);
      $display("txn conflict pair 2 grant=%0d", bus.grant);
      chk("c3_grant", bus.grant, 0);
      bus.mem_valid = 1'b1;
      step(1);
      chk("c3_f_valid", bus.f_valid, 1);
      bus.f_req = 1'b0; bus.l_req = 1'b0; bus.mem_valid = 1'b0;
      step(1);
      chk("c3_rel_busy", bus.busy, 0);
      step(1);
      chk("c3_no_regrant", bus.mem_req, 0);

      // ---------------- slow release ----------------
      bus.f_req = 1'b1; bus.f_addr = 32'h400;
      step(1);
      $display("txn slow release fetch addr=%h", bus.f_addr);
      chk("sr_mem_req", bus.mem_req, 1);
      bus.mem_valid = 1'b1; bus.mem_rdata = 32'h33333333;
      step(1);
      chk("sr_f_valid", bus.f_valid, 1);
      bus.f_req = 1'b0;
      bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h5000;
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk("sr_hold_f_valid", bus.f_valid, 1);
         chk("sr_hold_mem_req", bus.mem_req, 0);
         chk("sr_hold_busy", bus.busy, 1);
      end
      bus.mem_valid = 1'b0;
      step(1);
      chk("sr_rel_f_valid", bus.f_valid, 0);
      chk("sr_rel_busy", bus.busy, 0);
      chk("sr_rel_mem_req", bus.mem_req, 0);
      step(1);
      $display("txn pending lsu read addr=%h", bus.l_addr);
      chk("sr_pend_mem_req", bus.mem_req, 1);
      chk("sr_pend_grant", bus.grant, 1);
      chk("sr_pend_addr", bus.mem_addr, 32'h5000);
      bus.mem_valid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
      step(1);
      chk("sr_pend_l_valid", bus.l_valid, 1);
      chk("sr_pend_rdata", bus.rdata, 32'hCAFEF00D);
      bus.l_req = 1'b0; bus.mem_valid = 1'b0;
      step(1);
      chk("sr_pend_rel", bus.busy, 0);

      // ---------------- abort ----------------
      bus.l_req = 1'b1; bus.l_addr = 32'h6000;
      step(1);
      $display("txn lsu abort addr=%h", bus.l_addr);
      chk("ab_mem_req", bus.mem_req, 1);
      chk("ab_grant", bus.grant, 1);
      bus.l_req = 1'b0;
      step(1);
      chk("ab_busy_mem_req", bus.mem_req, 1);
      chk("ab_busy_l_valid", bus.l_valid, 0);
      bus.mem_valid = 1'b1; bus.mem_rdata = 32'h000055AA;
      step(1);
      chk("ab_done_l_valid", bus.l_valid, 0);
      chk("ab_done_mem_req", bus.mem_req, 0);
      chk("ab_done_busy", bus.busy, 1);
      bus.mem_valid = 1'b0;
      step(1);
      chk("ab_idle_busy", bus.busy, 0);
      chk("ab_idle_l_valid", bus.l_valid, 0);

      // ---------------- async reset ----------------
      bus.l_req = 1'b1; bus.l_addr = 32'h7000;
      step(1);
      chk("ar_pre_mem_req", bus.mem_req, 1);
      #2;
      rst = 1'b0;
      #1;
      $display("txn async reset mid-busy");
      chk("ar_mem_req", bus.mem_req, 0);
      chk("ar_busy", bus.busy, 0);
      chk("ar_f_valid", bus.f_valid, 0);
      chk("ar_l_valid", bus.l_valid, 0);
      chk("ar_mem_addr", bus.mem_addr, 0);
      chk("ar_rdata", bus.rdata, 0);
      bus.f_req = 1'b1; bus.f_addr = 32'h800;
      step(1);
      rst = 1'b1;
      step(1);
      $display("txn post-reset conflict grant=%0d", bus.grant);
      chk("ar_first_grant", bus.grant, 0);
      chk("ar_first_mem_req", bus.mem_req, 1);
      chk("ar_first_addr", bus.mem_addr, 32'h800);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
